// File: rtl/mod_counter_pkg.sv
// Shared types for the modulo counter: count mode and FSM state encodings.
package mod_counter_pkg;

  // Encoding 2'b11 is reserved and decoded as wrap.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/mod_counter.sv
// Up/down modulo counter with wrap / saturate / one-shot modes, clipped
// synchronous load and sticky overflow/underflow flags.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow,
  output logic             underflow,
  output logic             done
);

  localparam longint unsigned TOP_VAL = (64'd1 << WIDTH) - 64'd1;
  localparam logic [WIDTH-1:0] MAX_W  = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Parameter sanity: refuse to elaborate an unreachable or zero terminal value.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH must be in 2..32");
  end
  if (MAX_VAL < 64'd1 || MAX_VAL > TOP_VAL) begin : g_bad_max
    $error("mod_counter: MAX_VAL must be in 1..2**WIDTH-1");
  end

  state_e           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] load_clip;
  logic             set_ovf, set_unf;

  // Terminal depends on the live direction so a direction change acts at once.
  assign tc        = (up_dn && count == MAX_W) || (!up_dn && count == '0);
  assign load_clip = (load_val > MAX_W) ? MAX_W : load_val;

  // Next count/state: load beats step; DONE ignores en until reloaded.
  always_comb begin
    count_n = count;
    state_n = state;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (load) begin
      count_n = load_clip;
      if (state == ST_DONE) state_n = ST_COUNT;
    end else if (en && state != ST_DONE) begin
      state_n = ST_COUNT;
      if (tc) begin
        set_ovf = up_dn;
        set_unf = !up_dn;
        case (mode_e'(mode))
          MODE_SAT:     count_n = count;
          MODE_ONESHOT: state_n = ST_DONE;
          default:      count_n = up_dn ? '0 : MAX_W;
        endcase
      end else begin
        count_n = up_dn ? count + ONE_W : count - ONE_W;
      end
    end
  end

  // State, count, sticky flags and done; a same-edge flag set beats clr_flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      overflow  <= (overflow  && !clr_flags) || set_ovf;
      underflow <= (underflow && !clr_flags) || set_unf;
      done      <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: several parameterisations driven by a
// shared stimulus bus, each scenario checking its own instance.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, up_dn = 1'b1, load = 1'b0, clr_flags = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] load_val = 8'd0;
  logic [3:0] lv4;

  assign lv4 = load_val[3:0];

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // default 8-bit, MAX 255
  logic [7:0] c_d;  logic tc_d, ov_d, un_d, dn_d;
  // 4-bit, MAX 9
  logic [3:0] c_w;  logic tc_w, ov_w, un_w, dn_w;
  // 8-bit, MAX 100
  logic [7:0] c_s;  logic tc_s, ov_s, un_s, dn_s;
  // 8-bit, MAX 5
  logic [7:0] c_o;  logic tc_o, ov_o, un_o, dn_o;
  // 8-bit, MAX 150
  logic [7:0] c_l;  logic tc_l, ov_l, un_l, dn_l;

  mod_counter u_d (.clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .mode(mode),
    .load(load), .load_val(load_val), .clr_flags(clr_flags), .count(c_d), .tc(tc_d),
    .overflow(ov_d), .underflow(un_d), .done(dn_d));
  mod_counter #(.WIDTH(4), .MAX_VAL(9)) u_w (.clk(clk), .rst_n(rst_n), .en(en),
    .up_dn(up_dn), .mode(mode), .load(load), .load_val(lv4), .clr_flags(clr_flags),
    .count(c_w), .tc(tc_w), .overflow(ov_w), .underflow(un_w), .done(dn_w));
  mod_counter #(.WIDTH(8), .MAX_VAL(100)) u_s (.clk(clk), .rst_n(rst_n), .en(en),
    .up_dn(up_dn), .mode(mode), .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .count(c_s), .tc(tc_s), .overflow(ov_s), .underflow(un_s), .done(dn_s));
  mod_counter #(.WIDTH(8), .MAX_VAL(5)) u_o (.clk(clk), .rst_n(rst_n), .en(en),
    .up_dn(up_dn), .mode(mode), .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .count(c_o), .tc(tc_o), .overflow(ov_o), .underflow(un_o), .done(dn_o));
  mod_counter #(.WIDTH(8), .MAX_VAL(150)) u_l (.clk(clk), .rst_n(rst_n), .en(en),
    .up_dn(up_dn), .mode(mode), .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .count(c_l), .tc(tc_l), .overflow(ov_l), .underflow(un_l), .done(dn_l));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; load = 1'b0; clr_flags = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; load = 1'b0; clr_flags = 1'b0;
    #1;
    n_cmp++; if (c_d !== 8'd0)  begin n_err++; $display("FAIL reset_count got %0d exp 0", c_d); end
    n_cmp++; if (ov_d !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", ov_d); end
    n_cmp++; if (un_d !== 1'b0) begin n_err++; $display("FAIL reset_unf got %b exp 0", un_d); end
    n_cmp++; if (dn_d !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", dn_d); end
    n_cmp++; if (tc_d !== 1'b0) begin n_err++; $display("FAIL reset_tc got %b exp 0", tc_d); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    logic [7:0] e;
    do_reset();
    up_dn = 1'b1; mode = 2'd0; en = 1'b1;
    for (int i = 1; i <= 270; i++) begin
      tick();
      e = 8'(i % 256);
      n_cmp++; if (c_d !== e) begin n_err++; $display("FAIL wrap_up_count edge %0d got %0d exp %0d", i, c_d, e); end
      n_cmp++; if (tc_d !== (e == 8'd255)) begin n_err++; $display("FAIL wrap_up_tc edge %0d got %b exp %b", i, tc_d, (e == 8'd255)); end
      n_cmp++; if (ov_d !== (i >= 256)) begin n_err++; $display("FAIL wrap_up_ovf edge %0d got %b exp %b", i, ov_d, (i >= 256)); end
    end
    en = 1'b0;
  endtask

  task automatic test_clr_same_edge();
    en = 1'b0; clr_flags = 1'b1;
    tick();
    n_cmp++; if (ov_d !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %b exp 0", ov_d); end
    clr_flags = 1'b0; load = 1'b1; load_val = 8'd255;
    tick();
    n_cmp++; if (c_d !== 8'd255) begin n_err++; $display("FAIL clr_load_count got %0d exp 255", c_d); end
    n_cmp++; if (ov_d !== 1'b0)  begin n_err++; $display("FAIL clr_load_ovf got %b exp 0", ov_d); end
    load = 1'b0; en = 1'b1; clr_flags = 1'b1;
    tick();
    n_cmp++; if (c_d !== 8'd0)  begin n_err++; $display("FAIL clr_wrap_count got %0d exp 0", c_d); end
    n_cmp++; if (ov_d !== 1'b1) begin n_err++; $display("FAIL clr_set_wins got %b exp 1", ov_d); end
    en = 1'b0;
    tick();
    n_cmp++; if (ov_d !== 1'b0) begin n_err++; $display("FAIL clr_after got %b exp 0", ov_d); end
    clr_flags = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] e;
    do_reset();
    up_dn = 1'b0; mode = 2'd0; en = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      e = 4'((20 - i) % 10);
      n_cmp++; if (c_w !== e) begin n_err++; $display("FAIL down_count edge %0d got %0d exp %0d", i, c_w, e); end
      n_cmp++; if (un_w !== 1'b1) begin n_err++; $display("FAIL down_unf edge %0d got %b exp 1", i, un_w); end
    end
    en = 1'b0; clr_flags = 1'b1;
    tick();
    n_cmp++; if (un_w !== 1'b0) begin n_err++; $display("FAIL down_clr got %b exp 0", un_w); end
    n_cmp++; if (c_w !== 4'd9)  begin n_err++; $display("FAIL down_hold got %0d exp 9", c_w); end
    clr_flags = 1'b0;
  endtask

  task automatic test_saturate();
    logic [7:0] ec [4] = '{8'd99, 8'd100, 8'd100, 8'd100};
    logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    mode = 2'd1; up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'd98;
    tick();
    n_cmp++; if (c_s !== 8'd98) begin n_err++; $display("FAIL sat_load got %0d exp 98", c_s); end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (c_s !== ec[i])  begin n_err++; $display("FAIL sat_count %0d got %0d exp %0d", i, c_s, ec[i]); end
      n_cmp++; if (ov_s !== eo[i]) begin n_err++; $display("FAIL sat_ovf %0d got %b exp %b", i, ov_s, eo[i]); end
      n_cmp++; if (dn_s !== 1'b0)  begin n_err++; $display("FAIL sat_done %0d got %b exp 0", i, dn_s); end
    end
    en = 1'b0;
  endtask

  task automatic test_oneshot();
    do_reset();
    mode = 2'd2; up_dn = 1'b1; en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++; if (c_o !== 8'(i)) begin n_err++; $display("FAIL os_count %0d got %0d exp %0d", i, c_o, i); end
      n_cmp++; if (dn_o !== 1'b0) begin n_err++; $display("FAIL os_done_early %0d got %b exp 0", i, dn_o); end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (c_o !== 8'd5) begin n_err++; $display("FAIL os_hold %0d got %0d exp 5", i, c_o); end
      n_cmp++; if (dn_o !== 1'b1) begin n_err++; $display("FAIL os_done %0d got %b exp 1", i, dn_o); end
      n_cmp++; if (ov_o !== 1'b1) begin n_err++; $display("FAIL os_ovf %0d got %b exp 1", i, ov_o); end
    end
    en = 1'b0;
    tick();
    n_cmp++; if (dn_o !== 1'b1) begin n_err++; $display("FAIL os_done_en0 got %b exp 1", dn_o); end
    load = 1'b1; load_val = 8'd2;
    tick();
    n_cmp++; if (c_o !== 8'd2)  begin n_err++; $display("FAIL os_reload got %0d exp 2", c_o); end
    n_cmp++; if (dn_o !== 1'b0) begin n_err++; $display("FAIL os_reload_done got %b exp 0", dn_o); end
    load = 1'b0; en = 1'b1;
    tick();
    n_cmp++; if (c_o !== 8'd3)  begin n_err++; $display("FAIL os_resume got %0d exp 3", c_o); end
    repeat (3) tick();
    n_cmp++; if (dn_o !== 1'b1) begin n_err++; $display("FAIL os_done_again got %b exp 1", dn_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dn_o !== 1'b0) begin n_err++; $display("FAIL os_async_done got %b exp 0", dn_o); end
    n_cmp++; if (c_o !== 8'd0)  begin n_err++; $display("FAIL os_async_count got %0d exp 0", c_o); end
    #2 rst_n = 1'b1;
    en = 1'b0; mode = 2'd0;
  endtask

  task automatic test_load_clip();
    do_reset();
    mode = 2'd0; up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'd200;
    tick();
    n_cmp++; if (c_l !== 8'd150) begin n_err++; $display("FAIL clip_count got %0d exp 150", c_l); end
    n_cmp++; if (ov_l !== 1'b0)  begin n_err++; $display("FAIL clip_ovf got %b exp 0", ov_l); end
    n_cmp++; if (tc_l !== 1'b1)  begin n_err++; $display("FAIL clip_tc got %b exp 1", tc_l); end
    load = 1'b0;
    tick();
    n_cmp++; if (c_l !== 8'd0)  begin n_err++; $display("FAIL clip_wrap got %0d exp 0", c_l); end
    n_cmp++; if (ov_l !== 1'b1) begin n_err++; $display("FAIL clip_wrap_ovf got %b exp 1", ov_l); end
    en = 1'b0;
  endtask

  task automatic test_hold_dir();
    do_reset();
    mode = 2'd0; load = 1'b1; load_val = 8'd10;
    tick();
    load = 1'b0; en = 1'b0;
    tick();
    n_cmp++; if (c_d !== 8'd10) begin n_err++; $display("FAIL hold_en0 got %0d exp 10", c_d); end
    en = 1'b1; up_dn = 1'b1;
    tick();
    n_cmp++; if (c_d !== 8'd11) begin n_err++; $display("FAIL dir_up got %0d exp 11", c_d); end
    up_dn = 1'b0;
    tick();
    n_cmp++; if (c_d !== 8'd10) begin n_err++; $display("FAIL dir_down got %0d exp 10", c_d); end
    en = 1'b0; load = 1'b1; load_val = 8'd0;
    tick();
    load = 1'b0; #1;
    n_cmp++; if (tc_d !== 1'b1) begin n_err++; $display("FAIL tc_down_zero got %b exp 1", tc_d); end
    up_dn = 1'b1; #1;
    n_cmp++; if (tc_d !== 1'b0) begin n_err++; $display("FAIL tc_up_zero got %b exp 0", tc_d); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    up_dn = 1'b1; mode = 2'd0; en = 1'b1;
    repeat (255) tick();
    tick();
    repeat (77) tick();
    n_cmp++; if (c_d !== 8'd77) begin n_err++; $display("FAIL mid_count got %0d exp 77", c_d); end
    n_cmp++; if (ov_d !== 1'b1) begin n_err++; $display("FAIL mid_ovf got %b exp 1", ov_d); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (c_d !== 8'd0)  begin n_err++; $display("FAIL mid_rst_count got %0d exp 0", c_d); end
    n_cmp++; if (ov_d !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovf got %b exp 0", ov_d); end
    n_cmp++; if (un_d !== 1'b0) begin n_err++; $display("FAIL mid_rst_unf got %b exp 0", un_d); end
    #2 rst_n = 1'b1;
    tick();
    n_cmp++; if (c_d !== 8'd1)  begin n_err++; $display("FAIL mid_first_step got %0d exp 1", c_d); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_clr_same_edge();
    test_down_wrap();
    test_saturate();
    test_oneshot();
    test_load_clip();
    test_hold_dir();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (2..32).
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1, terminal value for up-counting; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have en  input  1  count enable.
REQ-005 SHALL have up_dn  input  1  direction: 1=up, 0=down.
REQ-006 SHALL have mode  input  2  0=WRAP, 1=SATURATE, 2=ONESHOT, 3=reserved and treated as WRAP.
REQ-007 SHALL have load  input  1  synchronous load strobe.
REQ-008 SHALL have load_val  input  WIDTH  load value, clipped to MAX_VAL.
REQ-009 SHALL have clr_flags  input  1  synchronous clear of the sticky flags.
REQ-010 SHALL have count  output  WIDTH  registered count.
REQ-011 SHALL have tc  output  1  combinational terminal count: (up_dn && count==MAX_VAL) || (!up_dn && count==0).
REQ-012 SHALL have overflow  output  1  sticky flag, set on an up-step at MAX_VAL.
REQ-013 SHALL have underflow  output  1  sticky flag, set on a down-step at 0.
REQ-014 SHALL have done  output  1  high while the FSM is in DONE.

Function
REQ-015 SHALL implement FSM states IDLE, COUNT and DONE.
REQ-016 IDLE SHALL move to COUNT on the first edge with en=1, and count SHALL step on that same edge.
REQ-017 COUNT SHALL move to DONE only when mode=ONESHOT, en=1 and tc=1 at the edge; count SHALL hold on that edge.
REQ-018 DONE SHALL hold count regardless of en; load SHALL move DONE to COUNT.
REQ-019 Per-edge priority SHALL be: reset > load > step.
REQ-020 load=1 SHALL write min(load_val, MAX_VAL) to count on the next edge, suppress the step and leave the flags unchanged.
REQ-021 Step with en=1 in IDLE or COUNT, not at terminal, SHALL make count = count+1 (up) or count-1 (down).
REQ-022 WRAP at terminal SHALL give: up MAX_VAL->0, down 0->MAX_VAL; the matching sticky flag SHALL be set.
REQ-023 SATURATE at terminal SHALL hold count, set the matching sticky flag and stay in COUNT.
REQ-024 ONESHOT at terminal SHALL hold count, set the matching sticky flag and move to DONE.
REQ-025 en=0 SHALL hold count, state and flags, except for load and clr_flags.
REQ-026 clr_flags SHALL clear both sticky flags on the next edge; if a flag-setting step occurs on the same edge, set SHALL win.
REQ-027 A change of up_dn or mode SHALL take effect on the next edge, with no pipeline delay.
REQ-028 All arithmetic SHALL be WIDTH bits with no implicit truncation warnings; MAX_VAL SHALL be compared at WIDTH bits.
REQ-029 Defaults with en=1, up_dn=1, mode=WRAP SHALL reproduce the legacy 8-bit free-running counter: 0->255->0, tc high exactly while count=255.

Reset
REQ-030 rst_n=0 SHALL immediately force count=0, overflow=0, underflow=0 and state=IDLE, so done=0.
REQ-031 Reset asserted mid-operation in any state SHALL take effect asynchronously; after release, the first en=1 edge SHALL produce count=1 when counting up.
REQ-032 Reset release SHALL be synchronised by the integrating design; the block SHALL NOT add a synchroniser.

Structure
REQ-033 A shared package mod_counter_pkg SHALL hold the mode enum (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and the FSM state enum.
REQ-034 There SHALL be a single module with no sub-modules: next-count logic combinational, state, count and flags in one always_ff.
REQ-035 An elaboration-time assertion SHALL reject MAX_VAL outside 1..2**WIDTH-1.

Verification
REQ-036 WIDTH=8 defaults, en=1, up, WRAP for 270 edges -> count 1..255,0..14; tc high only at count 255; overflow set after the 255->0 edge.
REQ-037 WIDTH=4, MAX_VAL=9, down, WRAP from 0 -> 9,8,...,0,9; underflow=1; clr_flags -> underflow=0 next edge.
REQ-038 WIDTH=8, MAX_VAL=100, SATURATE up, load 98 -> 99,100,100,100; overflow=1; state remains COUNT.
REQ-039 ONESHOT up, MAX_VAL=5, from 0 -> 1..5, then DONE with count=5 and done=1 while en=1; load 2 -> count=2, done=0, counting resumes.
REQ-040 load=1 and en=1 simultaneously with load_val=200, MAX_VAL=150 -> count=150 with no step; rst_n pulsed mid-count (count=77) -> count=0 immediately, flags 0, IDLE.
REQ-041 Same-edge clr_flags with a wrap from 255->0 -> overflow=1.
